// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and defaults for the fetch/data memory arbiter
package mem_arbiter_pkg;

    // Consecutive DM grants tolerated while an IF request waits.
    localparam int unsigned STARVE_LIMIT_DEF = 3;

    // Instruction fetches are always full-word, unsigned.
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        sign;
        owner_t      owner;
    } mem_cmd_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - shared memory bus between the arbiter (master) and memory (slave)
//   master: drives mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_size_o/mem_sign_o,
//           samples mem_gnt_i/mem_rvalid_i/mem_rdata_i
//   slave : the mirror image
interface mem_arbiter_if;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [1:0]  mem_size_o;
    logic        mem_sign_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_size_o, mem_sign_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_size_o, mem_sign_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );
endinterface

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - winner select (DM priority with IF anti-starvation) and streak counter
//   clk, rst_ni : clock, async active-low reset
//   arb_en_i    : arbitration slot this cycle (arbiter idle)
//   if_pend_i   : fetch request pending
//   dm_pend_i   : data request pending
//   if_win_o    : IF granted this cycle
//   dm_win_o    : DM granted this cycle
module mem_arb_pick
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic rst_ni,
    input  logic arb_en_i,
    input  logic if_pend_i,
    input  logic dm_pend_i,
    output logic if_win_o,
    output logic dm_win_o
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic [SW-1:0] streak_q, streak_d;
    logic          starved;

    assign starved = if_pend_i && (streak_q >= LIMIT);

    always_comb begin
        dm_win_o = 1'b0;
        if_win_o = 1'b0;
        streak_d = streak_q;
        if (arb_en_i) begin
            if (dm_pend_i && !starved) begin
                dm_win_o = 1'b1;
                // Only count DM wins that actually made a fetch wait; saturate at the limit.
                if (if_pend_i && (streak_q < LIMIT)) begin
                    streak_d = streak_q + 1'b1;
                end
            end else if (if_pend_i) begin
                if_win_o = 1'b1;
                streak_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-outstanding arbiter sharing one memory port between fetch and data
//   clk, rst_ni          : clock, async active-low reset
//   if_req_i/if_addr_i   : fetch request; if_flush_i squashes the outstanding fetch
//   if_rdata_o/if_valid_o/if_stall_o : fetch result, completion pulse, stall
//   dm_rd_en_i/dm_wr_en_i/dm_addr_i/dm_wdata_i/dm_size_i/dm_sign_i : data access
//   dm_rdata_o/dm_valid_o/dm_stall_o : load result, completion pulse, stall
//   mem                  : memory bus (master side)
//   err_o                : sticky error, response seen with nothing outstanding
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        rst_ni,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    input  logic        if_flush_i,
    output logic [31:0] if_rdata_o,
    output logic        if_valid_o,
    output logic        if_stall_o,
    input  logic        dm_rd_en_i,
    input  logic        dm_wr_en_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    input  logic [1:0]  dm_size_i,
    input  logic        dm_sign_i,
    output logic [31:0] dm_rdata_o,
    output logic        dm_valid_o,
    output logic        dm_stall_o,
    mem_arbiter_if.master mem,
    output logic        err_o
);

    arb_state_t  state_q, state_d;
    mem_cmd_t    cmd_q, cmd_d;
    logic        discard_q, discard_d;
    logic        err_q, err_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
    logic        if_valid_q, if_valid_d;
    logic        dm_valid_q, dm_valid_d;

    logic        dm_pend;
    logic        if_win, dm_win;

    assign dm_pend = dm_rd_en_i | dm_wr_en_i;

    mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
        .clk       (clk),
        .rst_ni    (rst_ni),
        .arb_en_i  (state_q == IDLE),
        .if_pend_i (if_req_i),
        .dm_pend_i (dm_pend),
        .if_win_o  (if_win),
        .dm_win_o  (dm_win)
    );

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        discard_d  = discard_q;
        err_d      = err_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_valid_d = 1'b0;
        dm_valid_d = 1'b0;

        if (mem.mem_rvalid_i && (state_q != RESP)) begin
            err_d = 1'b1;
        end

        // A squash only matters once the fetch is on the bus; it is remembered so the
        // late response can be swallowed.
        if (if_flush_i && (cmd_q.owner == OWN_IF) && (state_q != IDLE)) begin
            discard_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (dm_win) begin
                    cmd_d   = '{we: dm_wr_en_i, addr: dm_addr_i, wdata: dm_wdata_i,
                                size: dm_size_i, sign: dm_sign_i, owner: OWN_DM};
                    state_d = REQ;
                end else if (if_win) begin
                    cmd_d   = '{we: 1'b0, addr: if_addr_i, wdata: 32'h0,
                                size: SIZE_WORD, sign: 1'b0, owner: OWN_IF};
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem.mem_gnt_i) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (mem.mem_rvalid_i) begin
                    if (cmd_q.owner == OWN_IF) begin
                        if (!(discard_q || if_flush_i)) begin
                            if_rdata_d = mem.mem_rdata_i;
                            if_valid_d = 1'b1;
                        end
                    end else begin
                        if (!cmd_q.we) begin
                            dm_rdata_d = mem.mem_rdata_i;
                        end
                        dm_valid_d = 1'b1;
                    end
                    discard_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            discard_q  <= 1'b0;
            err_q      <= 1'b0;
            if_rdata_q <= 32'h0;
            dm_rdata_q <= 32'h0;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            discard_q  <= discard_d;
            err_q      <= err_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_valid_q <= if_valid_d;
            dm_valid_q <= dm_valid_d;
        end
    end

    // Bus is driven only while a command is being offered, so it reads as zero otherwise.
    always_comb begin
        mem.mem_req_o   = (state_q == REQ);
        mem.mem_we_o    = mem.mem_req_o & cmd_q.we;
        mem.mem_addr_o  = mem.mem_req_o ? cmd_q.addr  : 32'h0;
        mem.mem_wdata_o = mem.mem_req_o ? cmd_q.wdata : 32'h0;
        mem.mem_size_o  = mem.mem_req_o ? cmd_q.size  : 2'b00;
        mem.mem_sign_o  = mem.mem_req_o & cmd_q.sign;
    end

    assign if_rdata_o = if_rdata_q;
    assign dm_rdata_o = dm_rdata_q;
    assign if_valid_o = if_valid_q;
    assign dm_valid_o = dm_valid_q;
    assign if_stall_o = if_req_i & ~if_valid_q;
    assign dm_stall_o = dm_pend & ~dm_valid_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk;
    logic        rst_ni;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_flush_i;
    logic [31:0] if_rdata_o;
    logic        if_valid_o;
    logic        if_stall_o;
    logic        dm_rd_en_i;
    logic        dm_wr_en_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic [1:0]  dm_size_i;
    logic        dm_sign_i;
    logic [31:0] dm_rdata_o;
    logic        dm_valid_o;
    logic        dm_stall_o;
    logic        err_o;

    int n_checks;
    int n_fail;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk        (clk),
        .rst_ni     (rst_ni),
        .if_req_i   (if_req_i),
        .if_addr_i  (if_addr_i),
        .if_flush_i (if_flush_i),
        .if_rdata_o (if_rdata_o),
        .if_valid_o (if_valid_o),
        .if_stall_o (if_stall_o),
        .dm_rd_en_i (dm_rd_en_i),
        .dm_wr_en_i (dm_wr_en_i),
        .dm_addr_i  (dm_addr_i),
        .dm_wdata_i (dm_wdata_i),
        .dm_size_i  (dm_size_i),
        .dm_sign_i  (dm_sign_i),
        .dm_rdata_o (dm_rdata_o),
        .dm_valid_o (dm_valid_o),
        .dm_stall_o (dm_stall_o),
        .mem        (bus.master),
        .err_o      (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    logic [7:0] exp_dm_order;

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        rst_ni           = 1'b0;
        if_req_i         = 1'b0;
        if_addr_i        = 32'h0;
        if_flush_i       = 1'b0;
        dm_rd_en_i       = 1'b0;
        dm_wr_en_i       = 1'b0;
        dm_addr_i        = 32'h0;
        dm_wdata_i       = 32'h0;
        dm_size_i        = 2'b10;
        dm_sign_i        = 1'b0;
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = 32'h0;

        step(); step();
        check("rst_mem_req", {31'h0, bus.mem_req_o}, 32'h0);
        check("rst_mem_addr", bus.mem_addr_o, 32'h0);
        check("rst_dm_rdata", dm_rdata_o, 32'h0);
        check("rst_err", {31'h0, err_o}, 32'h0);
        rst_ni = 1'b1;
        step();

        // DM read 0x100, gnt in first REQ cycle, rvalid two cycles later
        dm_rd_en_i = 1'b1; dm_addr_i = 32'h100;
        #1;
        check("rd_dm_stall_idle", {31'h0, dm_stall_o}, 32'h1);
        step();
        check("rd_req", {31'h0, bus.mem_req_o}, 32'h1);
        check("rd_addr", bus.mem_addr_o, 32'h100);
        check("rd_we", {31'h0, bus.mem_we_o}, 32'h0);
        bus.mem_gnt_i = 1'b1;
        step();
        bus.mem_gnt_i = 1'b0;
        check("rd_req_resp", {31'h0, bus.mem_req_o}, 32'h0);
        step();
        check("rd_no_valid_early", {31'h0, dm_valid_o}, 32'h0);
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hDEADBEEF;
        step();
        bus.mem_rvalid_i = 1'b0;
        check("rd_dm_valid", {31'h0, dm_valid_o}, 32'h1);
        check("rd_dm_rdata", dm_rdata_o, 32'hDEADBEEF);
        check("rd_dm_stall_done", {31'h0, dm_stall_o}, 32'h0);
        check("rd_if_valid", {31'h0, if_valid_o}, 32'h0);
        dm_rd_en_i = 1'b0;
        step();
        check("rd_valid_one_cycle", {31'h0, dm_valid_o}, 32'h0);
        check("rd_idle_no_req", {31'h0, bus.mem_req_o}, 32'h0);

        // DM write with both enables set
        dm_rd_en_i = 1'b1; dm_wr_en_i = 1'b1; dm_addr_i = 32'h200; dm_wdata_i = 32'h55;
        step();
        check("wr_we", {31'h0, bus.mem_we_o}, 32'h1);
        check("wr_addr", bus.mem_addr_o, 32'h200);
        check("wr_wdata", bus.mem_wdata_o, 32'h55);
        bus.mem_gnt_i = 1'b1;
        step();
        bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hAAAA5555;
        step();
        bus.mem_rvalid_i = 1'b0;
        check("wr_dm_valid", {31'h0, dm_valid_o}, 32'h1);
        check("wr_rdata_kept", dm_rdata_o, 32'hDEADBEEF);
        dm_rd_en_i = 1'b0; dm_wr_en_i = 1'b0;
        step();

        // gnt withheld 5 cycles with both requesters pending
        if_req_i = 1'b1; if_addr_i = 32'h80;
        dm_rd_en_i = 1'b1; dm_addr_i = 32'h300;
        step();
        for (int i = 0; i < 5; i++) begin
            check("hold_req", {31'h0, bus.mem_req_o}, 32'h1);
            check("hold_addr", bus.mem_addr_o, 32'h300);
            check("hold_if_stall", {31'h0, if_stall_o}, 32'h1);
            check("hold_dm_stall", {31'h0, dm_stall_o}, 32'h1);
            step();
        end
        bus.mem_gnt_i = 1'b1;
        step();
        bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h1234;
        step();
        bus.mem_rvalid_i = 1'b0;
        check("hold_dm_valid", {31'h0, dm_valid_o}, 32'h1);
        check("hold_dm_rdata", dm_rdata_o, 32'h1234);
        dm_rd_en_i = 1'b0;
        step();
        check("if_addr", bus.mem_addr_o, 32'h80);
        check("if_we", {31'h0, bus.mem_we_o}, 32'h0);
        bus.mem_gnt_i = 1'b1;
        step();
        bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h777;
        step();
        bus.mem_rvalid_i = 1'b0;
        check("if_valid", {31'h0, if_valid_o}, 32'h1);
        check("if_rdata", if_rdata_o, 32'h777);
        check("if_stall_done", {31'h0, if_stall_o}, 32'h0);
        if_req_i = 1'b0;
        step();

        // starvation: both held, expected grant order DM,DM,DM,IF,DM,DM,DM,IF
        exp_dm_order = 8'b0111_0111;
        if_req_i = 1'b1; if_addr_i = 32'h40;
        dm_rd_en_i = 1'b1; dm_addr_i = 32'h300;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("order_%0d", i), bus.mem_addr_o, exp_dm_order[i] ? 32'h300 : 32'h40);
            bus.mem_gnt_i = 1'b1;
            step();
            bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h1000 + i;
            step();
            bus.mem_rvalid_i = 1'b0;
        end
        check("order_last_if_rdata", if_rdata_o, 32'h1007);
        if_req_i = 1'b0; dm_rd_en_i = 1'b0;
        step();

        // IF fetch squashed during RESP, then refetched
        if_req_i = 1'b1; if_addr_i = 32'h40;
        step();
        bus.mem_gnt_i = 1'b1;
        step();
        bus.mem_gnt_i = 1'b0; if_flush_i = 1'b1;
        step();
        if_flush_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h13;
        step();
        bus.mem_rvalid_i = 1'b0;
        check("flush_no_valid", {31'h0, if_valid_o}, 32'h0);
        check("flush_rdata_kept", if_rdata_o, 32'h1007);
        check("flush_if_stall", {31'h0, if_stall_o}, 32'h1);
        step();
        check("refetch_req", {31'h0, bus.mem_req_o}, 32'h1);
        check("refetch_addr", bus.mem_addr_o, 32'h40);
        bus.mem_gnt_i = 1'b1;
        step();
        bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h99;
        step();
        bus.mem_rvalid_i = 1'b0;
        check("refetch_valid", {31'h0, if_valid_o}, 32'h1);
        check("refetch_rdata", if_rdata_o, 32'h99);
        if_req_i = 1'b0;
        step();
        check("err_clean", {31'h0, err_o}, 32'h0);

        // reset mid-RESP, then a stale rvalid
        dm_rd_en_i = 1'b1; dm_addr_i = 32'h400;
        step();
        bus.mem_gnt_i = 1'b1;
        step();
        bus.mem_gnt_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        check("rstm_req", {31'h0, bus.mem_req_o}, 32'h0);
        check("rstm_addr", bus.mem_addr_o, 32'h0);
        check("rstm_if_rdata", if_rdata_o, 32'h0);
        check("rstm_dm_rdata", dm_rdata_o, 32'h0);
        check("rstm_dm_valid", {31'h0, dm_valid_o}, 32'h0);
        check("rstm_err", {31'h0, err_o}, 32'h0);
        dm_rd_en_i = 1'b0;
        step();
        rst_ni = 1'b1;
        step();
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hBAD;
        step();
        bus.mem_rvalid_i = 1'b0;
        check("late_err", {31'h0, err_o}, 32'h1);
        check("late_no_valid", {31'h0, dm_valid_o}, 32'h0);
        step();
        check("err_sticky", {31'h0, err_o}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT SHALL default to 3; it is the number of consecutive DM grants allowed while an IF request waits.
REQ-002 clk  input  1  core clock; all state SHALL update on rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-004 if_req_i  input  1  fetch request; if_addr_i  input  32  fetch address.
REQ-005 if_flush_i  input  1  hazard-unit squash of the outstanding fetch.
REQ-006 if_rdata_o  output  32  fetched word; if_valid_o  output  1  one-cycle completion pulse; if_stall_o  output  1  fetch not complete this cycle.
REQ-007 dm_rd_en_i, dm_wr_en_i  input  1 each  data read/write; dm_addr_i, dm_wdata_i  input  32 each; dm_size_i  input  2; dm_sign_i  input  1.
REQ-008 dm_rdata_o  output  32  load data; dm_valid_o  output  1  one-cycle completion pulse; dm_stall_o  output  1  data access not complete this cycle.
REQ-009 mem_req_o, mem_we_o  output  1 each; mem_addr_o, mem_wdata_o  output  32 each; mem_size_o  output  2; mem_sign_o  output  1.
REQ-010 mem_gnt_i  input  1  command accepted; mem_rvalid_i  input  1  read data or write ack; mem_rdata_i  input  32.
REQ-011 err_o  output  1  sticky protocol error.

Function
REQ-012 FSM states SHALL be IDLE, REQ, RESP; one memory transaction SHALL be outstanding at most.
REQ-013 IDLE: if a request is pending, the winner's command SHALL be latched into a command register with owner tag (IF/DM), then IDLE->REQ.
REQ-014 Arbitration: DM SHALL win over IF, except IF SHALL win when both are pending and streak >= STARVE_LIMIT.
REQ-015 streak SHALL increment (saturating) on each DM win while if_req_i=1; it SHALL clear on any IF win.
REQ-016 dm_wr_en_i=1 SHALL produce a write (mem_we_o=1) regardless of dm_rd_en_i.
REQ-017 REQ: mem_req_o=1, mem_* driven from the command register, stable until mem_gnt_i=1; on gnt, REQ->RESP.
REQ-018 RESP: on mem_rvalid_i=1, mem_rdata_i SHALL be registered into the owner's rdata output and the owner's valid output SHALL pulse the next cycle; RESP->IDLE.
REQ-019 Minimum latency, request to valid pulse: 4 cycles (IDLE, REQ+gnt, RESP+rvalid, valid).
REQ-020 if_rdata_o/dm_rdata_o SHALL hold their value until the next completion of the same owner; DM writes SHALL pulse dm_valid_o without updating dm_rdata_o.
REQ-021 if_stall_o = if_req_i & ~if_valid_o; dm_stall_o = (dm_rd_en_i|dm_wr_en_i) & ~dm_valid_o.
REQ-022 if_flush_i while IF owns REQ or RESP SHALL set a discard flag; the transaction SHALL complete on the bus and if_valid_o SHALL NOT pulse.
REQ-023 if_flush_i in IDLE, or while DM owns the bus, SHALL have no effect.
REQ-024 mem_rvalid_i outside RESP SHALL be ignored and SHALL set err_o; mem_gnt_i outside REQ SHALL be ignored.
REQ-025 A requester SHALL hold its request and command inputs until its valid pulse; changes before the pulse are not tracked.

Reset
REQ-026 rst_ni=0 SHALL immediately force IDLE, streak=0, discard=0, err_o=0, all mem_* outputs=0, valids=0, rdata outputs=0.
REQ-027 Reset during REQ or RESP SHALL abandon the transaction; a late mem_rvalid_i after reset release SHALL set err_o.

Structure
REQ-028 The shared util package SHALL hold arb_state_t (IDLE/REQ/RESP), mem_cmd_t (we, addr, wdata, size, sign, owner), and the STARVE_LIMIT default.
REQ-029 The block SHALL have one sub-module, mem_arb_pick: combinational winner select plus the streak counter.

Verification
REQ-030 DM read at 0x100 only, gnt at REQ+0, rvalid 2 cycles later with 0xDEADBEEF -> dm_valid_o pulse, dm_rdata_o=0xDEADBEEF, if side idle.
REQ-031 if_req_i and dm_rd_en_i held continuously, DM re-requesting each time -> grant order DM,DM,DM,IF,DM,... with STARVE_LIMIT=3.
REQ-032 IF fetch 0x40; if_flush_i during RESP; rvalid 0x13 -> no if_valid_o, if_rdata_o unchanged, next fetch proceeds normally.
REQ-033 DM write with dm_rd_en_i=dm_wr_en_i=1, addr 0x200, data 0x55 -> mem_we_o=1, mem_wdata_o=0x55, dm_valid_o pulse, dm_rdata_o unchanged.
REQ-034 mem_gnt_i held low 5 cycles in REQ -> mem_* stable for all 5 cycles, both stalls asserted for pending requesters.
REQ-035 rst_ni low mid-RESP, then spurious rvalid -> all outputs 0 during reset, err_o=1 after rvalid.
